// File: rtl/proc_hazard_ctrl.sv
// proc_hazard_ctrl
//   Hazard controller for the TinyRV1 in-order pipeline. A scoreboard with one
//   entry per post-decode stage (1 = X ... NSTAGES = W) tracks in-flight
//   register writes. From it, and from the instruction currently in D, the
//   block derives the operand bypass selects, the load-use and iterative-MUL
//   stalls, the branch/jump squashes and the W-stage register-file write port.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   d_val, d_kind      D-stage valid and class (0 ALU/ADDI, 1 LW, 2 MUL, 3 JUMP)
//   d_rs1_en/d_rs1     first source operand enable / register
//   d_rs2_en/d_rs2     second source operand enable / register
//   d_wen, d_rd        D instruction writes rd
//   x_redirect         taken branch resolved in X
//   stall_F, stall_D   hold the F and D registers
//   squash_F           kill the instruction entering D
//   squash_D           kill the instruction entering X
//   op1/op2_byp_sel    0 = register file, s = result of stage s
//   x_busy             iterative MUL still occupying X
//   rf_wen_W           W-stage write enable
//   rf_waddr_W         W-stage write address
module proc_hazard_ctrl #(
  parameter int NSTAGES = 3,
  parameter int NREGS   = 32,
  parameter int MUL_LAT = 1,
  localparam int AW = $clog2(NREGS),
  localparam int BW = $clog2(NSTAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_val,
  input  logic [1:0]    d_kind,
  input  logic          d_rs1_en,
  input  logic          d_rs2_en,
  input  logic [AW-1:0] d_rs1,
  input  logic [AW-1:0] d_rs2,
  input  logic [AW-1:0] d_rd,
  input  logic          d_wen,
  input  logic          x_redirect,
  output logic          stall_F,
  output logic          stall_D,
  output logic          squash_F,
  output logic          squash_D,
  output logic [BW-1:0] op1_byp_sel,
  output logic [BW-1:0] op2_byp_sel,
  output logic          x_busy,
  output logic          rf_wen_W,
  output logic [AW-1:0] rf_waddr_W
);

  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_LW  = 2'd1;
  localparam logic [1:0] K_MUL = 2'd2;
  localparam logic [1:0] K_JMP = 2'd3;

  // The counter only has to hold MUL_LAT-1; keep it at least one bit wide.
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  // Scoreboard, indexed by stage number.
  logic          sb_val [1:NSTAGES];
  logic          sb_wen [1:NSTAGES];
  logic [AW-1:0] sb_rd  [1:NSTAGES];
  logic [BW-1:0] sb_rdy [1:NSTAGES];

  logic [CW-1:0] mul_cnt;

  logic          raw1, raw2;
  logic [BW-1:0] sel1, sel2;
  logic          issue;
  logic [BW-1:0] new_rdy;

  // Returns {raw_hazard, byp_sel} for one source operand. The loop walks
  // from the oldest stage to the youngest so the youngest match is the one
  // left standing; a not-yet-ready youngest match therefore stalls even when
  // an older stage holds a ready copy of the same register.
  function automatic logic [BW:0] lookup(input logic en, input logic [AW-1:0] rs);
    logic          hit;
    logic [BW-1:0] s_hit;
    logic [BW-1:0] rdy_hit;
    hit     = 1'b0;
    s_hit   = '0;
    rdy_hit = '0;
    for (int s = NSTAGES; s >= 1; s--) begin
      if (sb_val[s] && sb_wen[s] && (sb_rd[s] == rs)) begin
        hit     = 1'b1;
        s_hit   = BW'(s);
        rdy_hit = sb_rdy[s];
      end
    end
    if (!en || (rs == '0) || !hit) begin
      return '0;
    end else if (s_hit >= rdy_hit) begin
      return {1'b0, s_hit};
    end else begin
      return {1'b1, {BW{1'b0}}};
    end
  endfunction

  always_comb begin
    {raw1, sel1} = lookup(d_val & d_rs1_en, d_rs1);
    {raw2, sel2} = lookup(d_val & d_rs2_en, d_rs2);
  end

  assign x_busy      = (mul_cnt != '0);
  // A taken branch kills D anyway, so it overrides any stall D would raise.
  assign stall_D     = (raw1 | raw2 | (d_val & x_busy)) & ~x_redirect;
  assign stall_F     = stall_D;
  assign squash_D    = x_redirect;
  // A jump only redirects fetch once it actually leaves D.
  assign squash_F    = x_redirect | (d_val & (d_kind == K_JMP) & ~stall_D);
  assign op1_byp_sel = sel1;
  assign op2_byp_sel = sel2;
  assign rf_wen_W    = sb_val[NSTAGES] & sb_wen[NSTAGES];
  assign rf_waddr_W  = sb_rd[NSTAGES];

  assign issue   = d_val & ~stall_D & ~squash_D;
  // Loads are first bypassable from stage 2; everything else from X.
  assign new_rdy = (d_kind == K_LW) ? BW'(2) : BW'(1);

  // Scoreboard advance and MUL occupancy counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 1; s <= NSTAGES; s++) begin
        sb_val[s] <= 1'b0;
        sb_wen[s] <= 1'b0;
        sb_rd[s]  <= '0;
        sb_rdy[s] <= '0;
      end
      mul_cnt <= '0;
    end else begin
      for (int s = NSTAGES; s >= 3; s--) begin
        sb_val[s] <= sb_val[s-1];
        sb_wen[s] <= sb_wen[s-1];
        sb_rd[s]  <= sb_rd[s-1];
        sb_rdy[s] <= sb_rdy[s-1];
      end
      if (x_busy) begin
        // MUL stays in X; a bubble drains into stage 2 behind it.
        sb_val[2] <= 1'b0;
        sb_wen[2] <= 1'b0;
        sb_rd[2]  <= '0;
        sb_rdy[2] <= '0;
      end else begin
        sb_val[2] <= sb_val[1];
        sb_wen[2] <= sb_wen[1];
        sb_rd[2]  <= sb_rd[1];
        sb_rdy[2] <= sb_rdy[1];
        if (issue) begin
          sb_val[1] <= 1'b1;
          sb_wen[1] <= d_wen;
          sb_rd[1]  <= d_rd;
          sb_rdy[1] <= new_rdy;
        end else begin
          sb_val[1] <= 1'b0;
          sb_wen[1] <= 1'b0;
          sb_rd[1]  <= '0;
          sb_rdy[1] <= '0;
        end
      end
      if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end else if ((MUL_LAT > 1) && issue && (d_kind == K_MUL)) begin
        mul_cnt <= CW'(MUL_LAT - 1);
      end
    end
  end

  // K_ALU documents the encoding; the datapath treats it as the default class.
  logic unused_kind;
  assign unused_kind = (K_ALU == 2'd0);

endmodule

// File: tb/tb_proc_hazard_ctrl.sv
// Directed testbench for proc_hazard_ctrl, NSTAGES = 3, MUL_LAT = 4.
module tb_proc_hazard_ctrl;
  localparam int NSTAGES = 3;
  localparam int NREGS   = 32;
  localparam int MUL_LAT = 4;
  localparam int AW      = 5;
  localparam int BW      = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_val;
  logic [1:0]    d_kind;
  logic          d_rs1_en, d_rs2_en;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic          d_wen;
  logic          x_redirect;
  logic          stall_F, stall_D, squash_F, squash_D;
  logic [BW-1:0] op1_byp_sel, op2_byp_sel;
  logic          x_busy;
  logic          rf_wen_W;
  logic [AW-1:0] rf_waddr_W;

  int checks = 0;
  int errors = 0;

  proc_hazard_ctrl #(.NSTAGES(NSTAGES), .NREGS(NREGS), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .d_val(d_val), .d_kind(d_kind),
    .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_wen(d_wen),
    .x_redirect(x_redirect),
    .stall_F(stall_F), .stall_D(stall_D),
    .squash_F(squash_F), .squash_D(squash_D),
    .op1_byp_sel(op1_byp_sel), .op2_byp_sel(op2_byp_sel),
    .x_busy(x_busy), .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the D-stage instruction, then let the combinational outputs settle.
  task automatic drive(input logic v, input logic [1:0] k,
                       input logic e1, input logic [4:0] r1,
                       input logic e2, input logic [4:0] r2,
                       input logic w, input logic [4:0] rd);
    d_val = v; d_kind = k;
    d_rs1_en = e1; d_rs1 = r1;
    d_rs2_en = e2; d_rs2 = r2;
    d_wen = w; d_rd = rd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // A taken branch in X must never coincide with an iterative MUL there.
  always @(negedge clk) begin
    if (rst === 1'b1 && x_redirect === 1'b1) begin
      checks++;
      assert (x_busy === 1'b0) else begin
        errors++;
        $error("FAIL redirect_vs_busy: observed x_busy %0d expected 0", x_busy);
      end
    end
  end

  initial begin
    rst = 1'b0;
    x_redirect = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    idle();
    chk("rst_stall_D", 32'(stall_D), 0);
    chk("rst_stall_F", 32'(stall_F), 0);
    chk("rst_squash_F", 32'(squash_F), 0);
    chk("rst_squash_D", 32'(squash_D), 0);
    chk("rst_op1", 32'(op1_byp_sel), 0);
    chk("rst_op2", 32'(op2_byp_sel), 0);
    chk("rst_busy", 32'(x_busy), 0);
    chk("rst_wen", 32'(rf_wen_W), 0);
    chk("rst_waddr", 32'(rf_waddr_W), 0);
    rst = 1'b1;

    // ADD x3 ; ADD x4,x3,x3
    drive(1, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3);
    chk("add1_stall", 32'(stall_D), 0);
    chk("add1_op1", 32'(op1_byp_sel), 0);
    tick();
    drive(1, 0, 1, 5'd3, 1, 5'd3, 1, 5'd4);
    chk("add2_op1", 32'(op1_byp_sel), 1);
    chk("add2_op2", 32'(op2_byp_sel), 1);
    chk("add2_stall", 32'(stall_D), 0);
    tick(); idle();
    chk("add_w_bubble", 32'(rf_wen_W), 0);
    tick();
    chk("add_w_wen3", 32'(rf_wen_W), 1);
    chk("add_w_addr3", 32'(rf_waddr_W), 3);
    tick();
    chk("add_w_addr4", 32'(rf_waddr_W), 4);
    repeat (3) tick();

    // LW x5 ; ADDI x6,x5 (load-use)
    drive(1, 1, 1, 5'd1, 0, 5'd0, 1, 5'd5);
    chk("lw_stall", 32'(stall_D), 0);
    tick();
    drive(1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd6);
    chk("lu_stall_D", 32'(stall_D), 1);
    chk("lu_stall_F", 32'(stall_F), 1);
    chk("lu_op1_hold", 32'(op1_byp_sel), 0);
    tick();
    drive(1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd6);
    chk("lu_stall_clear", 32'(stall_D), 0);
    chk("lu_op1_byp2", 32'(op1_byp_sel), 2);
    tick(); idle();
    chk("lw_w_wen", 32'(rf_wen_W), 1);
    chk("lw_w_addr", 32'(rf_waddr_W), 5);
    tick();
    chk("lw_w_after", 32'(rf_wen_W), 0);
    repeat (3) tick();

    // Youngest match: ADD x16 ; LW x16 ; reader of x16
    drive(1, 0, 1, 5'd1, 1, 5'd2, 1, 5'd16);
    tick();
    drive(1, 1, 1, 5'd1, 0, 5'd0, 1, 5'd16);
    chk("ym_lw_stall", 32'(stall_D), 0);
    tick();
    drive(1, 0, 1, 5'd16, 1, 5'd16, 1, 5'd17);
    chk("ym_stall", 32'(stall_D), 1);
    chk("ym_op1_hold", 32'(op1_byp_sel), 0);
    tick();
    drive(1, 0, 1, 5'd16, 1, 5'd16, 1, 5'd17);
    chk("ym_stall_clear", 32'(stall_D), 0);
    chk("ym_op1", 32'(op1_byp_sel), 2);
    chk("ym_op2", 32'(op2_byp_sel), 2);
    tick(); idle();
    repeat (3) tick();

    // MUL x7 ; ADD x8,x7 with MUL_LAT = 4
    drive(1, 2, 1, 5'd1, 1, 5'd2, 1, 5'd7);
    chk("mul_busy0", 32'(x_busy), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 5'd7, 1, 5'd2, 1, 5'd8);
      chk($sformatf("mul_busy_c%0d", i), 32'(x_busy), 1);
      chk($sformatf("mul_stallD_c%0d", i), 32'(stall_D), 1);
      chk($sformatf("mul_stallF_c%0d", i), 32'(stall_F), 1);
      tick();
    end
    drive(1, 0, 1, 5'd7, 1, 5'd2, 1, 5'd8);
    chk("mul_busy_done", 32'(x_busy), 0);
    chk("mul_stall_done", 32'(stall_D), 0);
    chk("mul_op1", 32'(op1_byp_sel), 1);
    tick(); idle();
    chk("mul_add_no_busy", 32'(x_busy), 0);
    chk("mul_w_bubble", 32'(rf_wen_W), 0);
    tick();
    chk("mul_w_wen", 32'(rf_wen_W), 1);
    chk("mul_w_addr", 32'(rf_waddr_W), 7);
    repeat (3) tick();

    // LW x9 ; dependent in D with redirect in the same cycle
    drive(1, 1, 1, 5'd1, 0, 5'd0, 1, 5'd9);
    tick();
    x_redirect = 1'b1;
    drive(1, 0, 1, 5'd9, 1, 5'd9, 1, 5'd10);
    chk("rd_stall_D", 32'(stall_D), 0);
    chk("rd_stall_F", 32'(stall_F), 0);
    chk("rd_squash_D", 32'(squash_D), 1);
    chk("rd_squash_F", 32'(squash_F), 1);
    tick();
    x_redirect = 1'b0;
    // x10 must not be found: the squashed ADD left a bubble in X.
    drive(1, 0, 1, 5'd10, 1, 5'd9, 1, 5'd11);
    chk("rd_bubble_op1", 32'(op1_byp_sel), 0);
    chk("rd_lw_op2", 32'(op2_byp_sel), 2);
    chk("rd_no_stall", 32'(stall_D), 0);
    chk("rd_squash_clear", 32'(squash_D), 0);
    tick(); idle();
    chk("rd_w_wen", 32'(rf_wen_W), 1);
    chk("rd_w_addr", 32'(rf_waddr_W), 9);
    repeat (3) tick();

    // ADDI x0 ; ADD reading x0 ; JAL ; LW x13 ; JR x13
    drive(1, 0, 1, 5'd1, 0, 5'd0, 1, 5'd0);
    tick();
    drive(1, 0, 1, 5'd0, 1, 5'd0, 1, 5'd12);
    chk("x0_op1", 32'(op1_byp_sel), 0);
    chk("x0_op2", 32'(op2_byp_sel), 0);
    chk("x0_stall", 32'(stall_D), 0);
    tick();
    drive(1, 3, 0, 5'd0, 0, 5'd0, 1, 5'd1);
    chk("jal_squash_F", 32'(squash_F), 1);
    chk("jal_squash_D", 32'(squash_D), 0);
    tick();
    drive(1, 1, 1, 5'd1, 0, 5'd0, 1, 5'd13);
    chk("jal_squash_once", 32'(squash_F), 0);
    tick();
    drive(1, 3, 1, 5'd13, 0, 5'd0, 0, 5'd0);
    chk("jr_stall", 32'(stall_D), 1);
    chk("jr_squash_defer", 32'(squash_F), 0);
    tick();
    drive(1, 3, 1, 5'd13, 0, 5'd0, 0, 5'd0);
    chk("jr_stall_clear", 32'(stall_D), 0);
    chk("jr_squash_F", 32'(squash_F), 1);
    chk("jr_op1", 32'(op1_byp_sel), 2);
    tick(); idle();
    repeat (3) tick();

    // Reset during the second busy cycle of an iterative MUL
    drive(1, 2, 1, 5'd1, 1, 5'd2, 1, 5'd14);
    tick(); idle();
    chk("rm_busy1", 32'(x_busy), 1);
    tick(); idle();
    chk("rm_busy2", 32'(x_busy), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1, 0, 1, 5'd14, 1, 5'd14, 1, 5'd15);
    chk("rm_busy_cleared", 32'(x_busy), 0);
    chk("rm_stall", 32'(stall_D), 0);
    chk("rm_op1", 32'(op1_byp_sel), 0);
    chk("rm_op2", 32'(op2_byp_sel), 0);
    chk("rm_wen", 32'(rf_wen_W), 0);
    chk("rm_waddr", 32'(rf_waddr_W), 0);
    tick(); idle();
    chk("rm_add_no_busy", 32'(x_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
